aim_batch_scheduler: RTL

- Sequencer in front of the 32-lane associative index matcher (AIM) in the object-tracking pipeline.
- Accepts a stream of 16-bit query words and packs them into batches of up to 32 lanes.
- Computes the iteration count from the active index-table length, launches the matcher and waits for finish with a watchdog.
- Serialises the per-lane hit/position results onto a valid/ready output stream.

---
 rtl/aim_pkg.sv | 39 +++
 rtl/aim_result_serializer.sv | 96 +++++++++
 rtl/aim_batch_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aim_pkg.sv
// Shared types and sizing for the AIM batch scheduler.
package aim_pkg;

    localparam int unsigned N_LANE    = 32;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned POS_W     = 9;
    localparam int unsigned IA_DEPTH  = 256;
    localparam int unsigned WD_CYCLES = 64;

    localparam int unsigned LEN_W  = 9;
    localparam int unsigned IDX_W  = $clog2(N_LANE);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned ITE_W  = 3;
    localparam int unsigned WD_W   = $clog2(WD_CYCLES);
    localparam int unsigned ERR_W  = 2;

    localparam int unsigned ERR_LEN = 0;
    localparam int unsigned ERR_WD  = 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic             hit;
        logic [POS_W-1:0] pos;
    } aim_result_t;

    // Matcher iterations minus one for a table of len entries (len in 1..IA_DEPTH).
    function automatic logic [ITE_W-1:0] calc_ite(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] len_m1;
        len_m1 = LEN_W'(len - LEN_W'(1));
        return ITE_W'(len_m1 >> IDX_W);
    endfunction

endpackage

// File: rtl/aim_result_serializer.sv
// Holds one batch of matcher results and streams lanes 0..n-1 over valid/ready.
module aim_result_serializer
    import aim_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load,
    input  logic                      i_miss,
    input  logic [CNT_W-1:0]          i_cnt,
    input  logic [N_LANE-1:0]         i_aim_valid,
    input  logic [N_LANE*POS_W-1:0]   i_aim_pos,
    input  logic                      i_r_ready,
    output logic                      o_r_valid,
    output logic [IDX_W-1:0]          o_r_idx,
    output logic                      o_r_hit,
    output logic [POS_W-1:0]          o_r_pos,
    output logic                      o_r_last,
    output logic                      o_done_c
);

    aim_result_t [N_LANE-1:0] res_q, res_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic                     valid_q, valid_d;
    logic                     hit_q, hit_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic                     last_q, last_d;
    logic                     hs_c;

    // Capture results on load, then advance one lane per accepted beat.
    always_comb begin
        res_d   = res_q;
        idx_d   = idx_q;
        n_d     = n_q;
        valid_d = valid_q;
        hit_d   = hit_q;
        pos_d   = pos_q;
        last_d  = last_q;
        hs_c    = valid_q & i_r_ready;

        if (i_load) begin
            for (int k = 0; k < int'(N_LANE); k++) begin
                res_d[k].hit = ~i_miss & i_aim_valid[k];
                res_d[k].pos = res_d[k].hit ? i_aim_pos[k*POS_W +: POS_W] : '0;
            end
            n_d     = i_cnt;
            idx_d   = '0;
            valid_d = 1'b1;
            hit_d   = res_d[0].hit;
            pos_d   = res_d[0].pos;
            last_d  = (i_cnt == CNT_W'(1));
        end else if (hs_c) begin
            if (last_q) begin
                valid_d = 1'b0;
                idx_d   = '0;
                hit_d   = 1'b0;
                pos_d   = '0;
                last_d  = 1'b0;
            end else begin
                idx_d  = IDX_W'(idx_q + IDX_W'(1));
                hit_d  = res_q[idx_d].hit;
                pos_d  = res_q[idx_d].pos;
                last_d = (CNT_W'(CNT_W'(idx_d) + CNT_W'(1)) == n_q);
            end
        end
    end

    // Result and beat registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            pos_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            res_q   <= res_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            pos_q   <= pos_d;
            last_q  <= last_d;
        end
    end

    assign o_r_valid = valid_q;
    assign o_r_idx   = idx_q;
    assign o_r_hit   = hit_q;
    assign o_r_pos   = pos_q;
    assign o_r_last  = last_q;
    assign o_done_c  = hs_c & last_q;

endmodule

// File: rtl/aim_batch_scheduler.sv
// Packs query words into lane batches, launches the AIM matcher with a
// watchdog, and hands the per-lane results to the serializer.
module aim_batch_scheduler
    import aim_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [LEN_W-1:0]          i_ia_len,
    input  logic                      i_q_valid,
    output logic                      o_q_ready,
    input  logic [WORD_W-1:0]         i_q_word,
    input  logic                      i_q_last,
    output logic                      o_aim_start,
    output logic [ITE_W-1:0]          o_aim_ite,
    output logic [N_LANE*WORD_W-1:0]  o_aim_word,
    input  logic                      i_aim_finish,
    input  logic [N_LANE-1:0]         i_aim_valid,
    input  logic [N_LANE*POS_W-1:0]   i_aim_pos,
    output logic                      o_r_valid,
    input  logic                      i_r_ready,
    output logic [IDX_W-1:0]          o_r_idx,
    output logic                      o_r_hit,
    output logic [POS_W-1:0]          o_r_pos,
    output logic                      o_r_last,
    output logic                      o_busy,
    output logic [ERR_W-1:0]          o_err,
    input  logic                      i_clr_err
);

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [N_LANE-1:0][WORD_W-1:0]    lane_q, lane_d;
    logic [ITE_W-1:0]                 ite_q, ite_d;
    logic                             start_q, start_d;
    logic                             q_ready_q, q_ready_d;
    logic                             busy_q, busy_d;
    logic [ERR_W-1:0]                 err_q, err_d;
    logic [WD_W-1:0]                  wd_q, wd_d;
    logic [LEN_W-1:0]                 len_c;
    logic                             q_acc_c;
    logic                             ld_c;
    logic                             ld_miss_c;
    logic                             done_c;

    // Next-state, lane fill, launch, watchdog and sticky error logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        ite_d     = ite_q;
        start_d   = 1'b0;
        err_d     = i_clr_err ? '0 : err_q;
        wd_d      = wd_q;
        len_c     = i_ia_len;
        ld_c      = 1'b0;
        ld_miss_c = 1'b0;
        q_acc_c   = (state_q == S_FILL) & q_ready_q & i_q_valid;

        unique case (state_q)
            S_FILL: begin
                if (q_acc_c) begin
                    lane_d[cnt_q[IDX_W-1:0]] = i_q_word;
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == CNT_W'(N_LANE - 1) || i_q_last) begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (i_ia_len > LEN_W'(IA_DEPTH)) begin
                    len_c          = LEN_W'(IA_DEPTH);
                    err_d[ERR_LEN] = 1'b1;
                end
                if (i_ia_len == '0) begin
                    err_d[ERR_LEN] = 1'b1;
                    ld_c           = 1'b1;
                    ld_miss_c      = 1'b1;
                    state_d        = S_DRAIN;
                end else begin
                    ite_d   = calc_ite(len_c);
                    start_d = 1'b1;
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_aim_finish) begin
                    ld_c    = 1'b1;
                    state_d = S_DRAIN;
                end else if (wd_q == WD_W'(WD_CYCLES - 1)) begin
                    err_d[ERR_WD] = 1'b1;
                    ld_c          = 1'b1;
                    ld_miss_c     = 1'b1;
                    state_d       = S_DRAIN;
                end else begin
                    wd_d = WD_W'(wd_q + WD_W'(1));
                end
            end
            S_DRAIN: begin
                if (done_c) begin
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        q_ready_d = (state_d == S_FILL);
        busy_d    = (state_d != S_FILL);
    end

    // Control, lane and status registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_FILL;
            cnt_q     <= '0;
            lane_q    <= '0;
            ite_q     <= '0;
            start_q   <= 1'b0;
            q_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            ite_q     <= ite_d;
            start_q   <= start_d;
            q_ready_q <= q_ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    aim_result_serializer u_ser (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (ld_c),
        .i_miss      (ld_miss_c),
        .i_cnt       (cnt_q),
        .i_aim_valid (i_aim_valid),
        .i_aim_pos   (i_aim_pos),
        .i_r_ready   (i_r_ready),
        .o_r_valid   (o_r_valid),
        .o_r_idx     (o_r_idx),
        .o_r_hit     (o_r_hit),
        .o_r_pos     (o_r_pos),
        .o_r_last    (o_r_last),
        .o_done_c    (done_c)
    );

    assign o_q_ready   = q_ready_q;
    assign o_aim_start = start_q;
    assign o_aim_ite   = ite_q;
    assign o_aim_word  = lane_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

endmodule
